vga_frame_monitor: RTL and testbench
====================================

Name: vga_frame_monitor

Overview:
- Receive-side counterpart of the VGA pixel output path: sinks hsync/vsync/blank_n and 24-bit RGB as driven to the DAC.
- Recovers line and frame structure from the sync pulses and checks active-region geometry.
- Produces a per-frame signature (checksum, lit-pixel count, line count) for self-check on hardware and in simulation.
- Sits beside the game top-level, tapping the VGA outputs; it has no effect on the display.

Parameters:
- H_ACTIVE, 640, expected active pixels per line
- V_ACTIVE, 480, expected active lines per frame
- SYNC_ACTIVE_LOW, 1, 1 = hsync/vsync asserted low

Ports:
- clk  input  1  system clock (50 MHz)
- rst  input  1  asynchronous, active-high reset
- pix_en  input  1  pixel strobe, one clk cycle per pixel; all inputs below are sampled only when high
- hsync  input  1  horizontal sync
- vsync  input  1  vertical sync
- blank_n  input  1  high = active pixel
- vga_r  input  8  red
- vga_g  input  8  green
- vga_b  input  8  blue
- locked  output  1  first frame boundary seen
- frame_valid  output  1  one-cycle pulse; frame_* outputs updated
- frame_sig  output  32  checksum of the completed frame
- frame_lit  output  19  active pixels with non-zero RGB
- frame_lines  output  10  active lines in the frame
- line_err  output  1  sticky per frame: some line had active count != H_ACTIVE
- frame_err  output  1  frame_lines != V_ACTIVE, or line_err set

Behaviour:
- Reset values:
  - All outputs 0.
  - Internal counters and sig_acc 0.
  - State SEARCH.
  - Sync history registers hold the deasserted level.
- Sync assertion edge:
  - Detected on pix_en cycles only, comparing the current sample with the previous sample (asserted per SYNC_ACTIVE_LOW).
  - Sync level is ignored; only edges count.
- State SEARCH:
  - Pixels are ignored and accumulators are held at 0.
  - On a vsync edge: go to LOCKED, locked<=1, no frame_valid.
- State LOCKED, per pix_en cycle with blank_n=1:
  - x_cnt+1, saturating at 1023.
  - sig_acc <= {sig_acc[30:0],sig_acc[31]} XOR {8'h00,r,g,b}.
  - If rgb != 0: lit_acc+1, saturating at 2^19-1.
  - line_active <= 1.
- hsync edge, when line_active=1:
  - y_cnt+1, saturating at 1023.
  - If x_cnt != H_ACTIVE: line_err_acc <= 1.
  - Clear x_cnt and line_active.
  - A hsync edge with line_active=0 (blanking line) only clears x_cnt.
- vsync edge in LOCKED:
  - Register frame_sig=sig_acc, frame_lit=lit_acc, frame_lines=y_cnt, line_err=line_err_acc.
  - frame_err = (y_cnt != V_ACTIVE) | line_err_acc.
  - frame_valid=1 for exactly the next clk cycle.
  - Clear all accumulators.
- Latency: frame_* outputs and the frame_valid pulse appear 1 clk after the pix_en cycle carrying the vsync edge.
- Simultaneous hsync and vsync edges on the same strobe, with line_active=1:
  - The line closes first and is counted in this frame.
  - If blank_n=1 on that strobe, that pixel is also accumulated before close.
- Frame outputs hold their values until the next frame_valid.
- Reset mid-frame: immediate asynchronous clear and return to SEARCH; the partial frame is discarded and no frame_valid is issued.
- pix_en=0 cycles: no state change except frame_valid deasserting.

Decomposition:
- Shared package vga_pkg holds the timing constants (H_ACTIVE, V_ACTIVE, H_TOTAL=800, V_TOTAL=525) and the state enum {SEARCH, LOCKED}, shared with the VGA driver.
- One sub-module, vga_sync_edge: per-signal sample register plus polarity-aware edge pulse, gated by pix_en; instantiated twice (hsync and vsync).

Test Plan:
- Reset, then 3 full 800x525 frames of all-black RGB with correct 640x480 active region:
  - locked=1 after the first vsync edge.
  - Two frame_valid pulses.
  - frame_lit=0, frame_lines=480, frame_sig=0, line_err=0, frame_err=0.
- Frame with a single pixel 24'hFFFFFF at x=0,y=0, rest black:
  - frame_lit=1, frame_lines=480.
  - frame_sig equals the reference-model rotate-XOR value; frame_err=0.
- One line driven with 639 active pixels: line_err=1, frame_err=1, frame_lines=480.
- Frame with only 479 active lines: frame_lines=479, frame_err=1, line_err=0.
- hsync and vsync edges on the same strobe at the end of the last active line: that line counted, frame_lines=480.
- rst asserted mid-frame at line 200:
  - All outputs 0 within the same cycle.
  - No frame_valid until after a vsync edge re-locks and a further full frame completes.

Source files
------------

// File: rtl/vga_pkg.sv
// Timing constants and state encoding shared by the VGA driver and the frame monitor.
package vga_pkg;

    localparam int H_ACTIVE = 640;
    localparam int V_ACTIVE = 480;
    localparam int H_TOTAL  = 800;
    localparam int V_TOTAL  = 525;

    typedef logic [0:0] vga_state_t;

    localparam vga_state_t SEARCH = 1'b0;
    localparam vga_state_t LOCKED = 1'b1;

    function automatic logic [9:0] sat_inc10(input logic [9:0] value);
        return (value == 10'h3FF) ? value : value + 10'd1;
    endfunction

    function automatic logic [18:0] sat_inc19(input logic [18:0] value);
        return (value == 19'h7FFFF) ? value : value + 19'd1;
    endfunction

endpackage

// File: rtl/vga_sync_edge.sv
// Samples one sync line on pixel strobes and pulses when it newly becomes asserted.
module vga_sync_edge
    import vga_pkg::*;
#(
    parameter bit SYNC_ACTIVE_LOW = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic pix_en,
    input  logic sync,
    output logic sync_edge
);

    logic asserted;
    logic prev_asserted;

    assign asserted = SYNC_ACTIVE_LOW ? ~sync : sync;

    // History resets to the deasserted level so a sync already low at release still counts as an edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prev_asserted <= 1'b0;
        end else if (pix_en) begin
            prev_asserted <= asserted;
        end
    end

    assign sync_edge = pix_en & asserted & ~prev_asserted;

endmodule

// File: rtl/vga_frame_monitor.sv
// Taps the VGA output stream, recovers line/frame structure from sync edges and
// reports a per-frame signature plus geometry error flags.
module vga_frame_monitor #(
    parameter int H_ACTIVE        = vga_pkg::H_ACTIVE,
    parameter int V_ACTIVE        = vga_pkg::V_ACTIVE,
    parameter bit SYNC_ACTIVE_LOW = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        pix_en,
    input  logic        hsync,
    input  logic        vsync,
    input  logic        blank_n,
    input  logic [7:0]  vga_r,
    input  logic [7:0]  vga_g,
    input  logic [7:0]  vga_b,
    output logic        locked,
    output logic        frame_valid,
    output logic [31:0] frame_sig,
    output logic [18:0] frame_lit,
    output logic [9:0]  frame_lines,
    output logic        line_err,
    output logic        frame_err
);

    import vga_pkg::*;

    logic        h_edge;
    logic        v_edge;
    vga_state_t  state;

    logic [9:0]  x_cnt;
    logic [9:0]  y_cnt;
    logic [31:0] sig_acc;
    logic [18:0] lit_acc;
    logic        line_active;
    logic        line_err_acc;

    logic [23:0] rgb;
    logic [9:0]  x_px;
    logic [31:0] sig_px;
    logic [18:0] lit_px;
    logic        active_px;

    logic [9:0]  x_ln;
    logic [9:0]  y_ln;
    logic        active_ln;
    logic        err_ln;

    vga_sync_edge #(
        .SYNC_ACTIVE_LOW(SYNC_ACTIVE_LOW)
    ) u_hsync_edge (
        .clk      (clk),
        .rst      (rst),
        .pix_en   (pix_en),
        .sync     (hsync),
        .sync_edge(h_edge)
    );

    vga_sync_edge #(
        .SYNC_ACTIVE_LOW(SYNC_ACTIVE_LOW)
    ) u_vsync_edge (
        .clk      (clk),
        .rst      (rst),
        .pix_en   (pix_en),
        .sync     (vsync),
        .sync_edge(v_edge)
    );

    assign rgb = {vga_r, vga_g, vga_b};

    // Pixel is folded in before any line close so a strobe carrying both still counts.
    always_comb begin
        x_px      = x_cnt;
        sig_px    = sig_acc;
        lit_px    = lit_acc;
        active_px = line_active;
        if (blank_n) begin
            x_px      = sat_inc10(x_cnt);
            sig_px    = {sig_acc[30:0], sig_acc[31]} ^ {8'h00, rgb};
            lit_px    = (rgb != 24'h0) ? sat_inc19(lit_acc) : lit_acc;
            active_px = 1'b1;
        end
    end

    // Line close runs before the frame close, so a coincident vsync sees the finished line.
    always_comb begin
        x_ln      = x_px;
        y_ln      = y_cnt;
        active_ln = active_px;
        err_ln    = line_err_acc;
        if (h_edge) begin
            x_ln      = 10'd0;
            active_ln = 1'b0;
            if (active_px) begin
                y_ln = sat_inc10(y_cnt);
                if (x_px != 10'(H_ACTIVE)) begin
                    err_ln = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= SEARCH;
            locked       <= 1'b0;
            frame_valid  <= 1'b0;
            frame_sig    <= 32'h0;
            frame_lit    <= 19'h0;
            frame_lines  <= 10'h0;
            line_err     <= 1'b0;
            frame_err    <= 1'b0;
            x_cnt        <= 10'h0;
            y_cnt        <= 10'h0;
            sig_acc      <= 32'h0;
            lit_acc      <= 19'h0;
            line_active  <= 1'b0;
            line_err_acc <= 1'b0;
        end else begin
            frame_valid <= 1'b0;
            if (pix_en) begin
                if (state == SEARCH) begin
                    if (v_edge) begin
                        state  <= LOCKED;
                        locked <= 1'b1;
                    end
                end else if (v_edge) begin
                    frame_sig    <= sig_px;
                    frame_lit    <= lit_px;
                    frame_lines  <= y_ln;
                    line_err     <= err_ln;
                    frame_err    <= (y_ln != 10'(V_ACTIVE)) | err_ln;
                    frame_valid  <= 1'b1;
                    x_cnt        <= 10'h0;
                    y_cnt        <= 10'h0;
                    sig_acc      <= 32'h0;
                    lit_acc      <= 19'h0;
                    line_active  <= 1'b0;
                    line_err_acc <= 1'b0;
                end else begin
                    x_cnt        <= x_ln;
                    y_cnt        <= y_ln;
                    sig_acc      <= sig_px;
                    lit_acc      <= lit_px;
                    line_active  <= active_ln;
                    line_err_acc <= err_ln;
                end
            end
        end
    end

endmodule

// File: tb/tb_vga_frame_monitor.sv
// Directed bench for vga_frame_monitor on a scaled-down raster; expected frame
// results are queued as each frame is driven and checked on every frame_valid.
module tb_vga_frame_monitor;

    localparam int H    = 16;
    localparam int V    = 12;
    localparam int HT   = 20;
    localparam int VT   = 17;
    localparam int HS_X = H + 1;

    logic        clk;
    logic        rst;
    logic        pix_en;
    logic        hsync;
    logic        vsync;
    logic        blank_n;
    logic [7:0]  vga_r;
    logic [7:0]  vga_g;
    logic [7:0]  vga_b;
    logic        locked;
    logic        frame_valid;
    logic [31:0] frame_sig;
    logic [18:0] frame_lit;
    logic [9:0]  frame_lines;
    logic        line_err;
    logic        frame_err;

    typedef struct {
        logic [31:0] sig;
        logic [18:0] lit;
        logic [9:0]  lines;
        logic        line_err;
        logic        frame_err;
    } exp_t;

    exp_t exp_q[$];
    int   compared    = 0;
    int   mismatched  = 0;
    int   valid_count = 0;
    int   snap;

    vga_frame_monitor #(
        .H_ACTIVE       (H),
        .V_ACTIVE       (V),
        .SYNC_ACTIVE_LOW(1'b1)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .pix_en     (pix_en),
        .hsync      (hsync),
        .vsync      (vsync),
        .blank_n    (blank_n),
        .vga_r      (vga_r),
        .vga_g      (vga_g),
        .vga_b      (vga_b),
        .locked     (locked),
        .frame_valid(frame_valid),
        .frame_sig  (frame_sig),
        .frame_lit  (frame_lit),
        .frame_lines(frame_lines),
        .line_err   (line_err),
        .frame_err  (frame_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        compared++;
        assert (observed === expected) else begin
            mismatched++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    function automatic logic [31:0] rotl(input logic [31:0] value, input int n);
        logic [31:0] v = value;
        for (int i = 0; i < n; i++) v = {v[30:0], v[31]};
        return v;
    endfunction

    // One pixel strobe followed by one idle cycle carrying junk the DUT must ignore.
    task automatic apply_stimulus(input bit hs_a, input bit vs_a, input bit blank, input logic [23:0] rgb);
        @(posedge clk);
        #1;
        pix_en  = 1'b1;
        hsync   = ~hs_a;
        vsync   = ~vs_a;
        blank_n = blank;
        {vga_r, vga_g, vga_b} = rgb;
        @(posedge clk);
        #1;
        pix_en  = 1'b0;
        hsync   = 1'($urandom);
        vsync   = 1'($urandom);
        blank_n = 1'b1;
        {vga_r, vga_g, vga_b} = 24'($urandom);
    endtask

    task automatic send_line(input int n_px, input int hs_x, input int vs_x, input logic [23:0] first_rgb);
        for (int x = 0; x < HT; x++) begin
            apply_stimulus((x >= hs_x) && (x < hs_x + 2), (vs_x >= 0) && (x >= vs_x),
                           x < n_px, (x == 0) ? first_rgb : 24'h0);
        end
    endtask

    task automatic send_frame(input int n_lines, input int short_y, input logic [23:0] first_rgb, input bit combined);
        exp_t e;
        int   px;
        bit   last;
        px          = n_lines * H - ((short_y >= 0) ? 1 : 0);
        e.sig       = rotl({8'h00, first_rgb}, (px - 1) % 32);
        e.lit       = (first_rgb != 24'h0) ? 19'd1 : 19'd0;
        e.lines     = 10'(n_lines);
        e.line_err  = (short_y >= 0);
        e.frame_err = (short_y >= 0) || (n_lines != V);
        send_line(0, HS_X, 0, 24'h0);
        send_line(0, HS_X, 0, 24'h0);
        send_line(0, HS_X, -1, 24'h0);
        exp_q.push_back(e);
        for (int y = 0; y < n_lines; y++) begin
            last = combined && (y == n_lines - 1);
            send_line((y == short_y) ? H - 1 : H, last ? H : HS_X, last ? H : -1,
                      (y == 0) ? first_rgb : 24'h0);
        end
        if (!combined) begin
            for (int y = 0; y < VT - 3 - n_lines; y++) send_line(0, HS_X, -1, 24'h0);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (frame_valid === 1'b1) begin
            valid_count++;
            if (exp_q.size() == 0) begin
                compared++;
                mismatched++;
                $error("[TB] FAIL unexpected_valid: observed pulse expected none");
            end else begin
                e = exp_q.pop_front();
                check_output("frame_sig", frame_sig, e.sig);
                check_output("frame_lit", 32'(frame_lit), 32'(e.lit));
                check_output("frame_lines", 32'(frame_lines), 32'(e.lines));
                check_output("line_err", 32'(line_err), 32'(e.line_err));
                check_output("frame_err", 32'(frame_err), 32'(e.frame_err));
                check_output("locked_at_valid", 32'(locked), 32'd1);
            end
        end
    end

    initial begin
        rst     = 1'b1;
        pix_en  = 1'b0;
        hsync   = 1'b1;
        vsync   = 1'b1;
        blank_n = 1'b0;
        {vga_r, vga_g, vga_b} = 24'h0;
        repeat (3) @(posedge clk);
        #1;
        check_output("reset_locked", 32'(locked), 32'd0);
        check_output("reset_valid", 32'(frame_valid), 32'd0);
        check_output("reset_sig", frame_sig, 32'd0);
        check_output("reset_lines", 32'(frame_lines), 32'd0);
        rst = 1'b0;

        $display("[TB] three black frames");
        send_frame(V, -1, 24'h0, 1'b0);
        check_output("locked_after_vsync", 32'(locked), 32'd1);
        check_output("no_valid_on_lock", 32'(valid_count), 32'd0);
        send_frame(V, -1, 24'h0, 1'b0);
        send_frame(V, -1, 24'h0, 1'b0);
        check_output("valid_count_3frames", 32'(valid_count), 32'd2);

        $display("[TB] single white pixel, short line, short frame, coincident syncs");
        send_frame(V, -1, 24'hFFFFFF, 1'b0);
        send_frame(V, 5, 24'h0, 1'b0);
        send_frame(V - 1, -1, 24'h0, 1'b0);
        send_frame(V, -1, 24'h0, 1'b1);
        send_frame(V, -1, 24'h123456, 1'b0);

        $display("[TB] reset mid-frame");
        send_line(0, HS_X, 0, 24'h0);
        send_line(0, HS_X, 0, 24'h0);
        send_line(0, HS_X, -1, 24'h0);
        for (int y = 0; y < 6; y++) send_line(H, HS_X, -1, 24'h0);
        check_output("pending_before_reset", 32'(exp_q.size()), 32'd0);
        check_output("sig_before_reset", frame_sig, rotl(32'h00123456, (V * H - 1) % 32));
        @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check_output("midrst_locked", 32'(locked), 32'd0);
        check_output("midrst_valid", 32'(frame_valid), 32'd0);
        check_output("midrst_sig", frame_sig, 32'd0);
        check_output("midrst_lit", 32'(frame_lit), 32'd0);
        check_output("midrst_lines", 32'(frame_lines), 32'd0);
        check_output("midrst_line_err", 32'(line_err), 32'd0);
        check_output("midrst_frame_err", 32'(frame_err), 32'd0);
        repeat (3) @(posedge clk);
        #1;
        rst  = 1'b0;
        snap = valid_count;

        send_frame(V, -1, 24'h0, 1'b0);
        check_output("no_valid_on_relock", 32'(valid_count), 32'(snap));
        send_frame(V, -1, 24'h000001, 1'b0);
        check_output("valid_after_relock", 32'(valid_count), 32'(snap + 1));
        send_line(0, HS_X, 0, 24'h0);
        repeat (10) @(posedge clk);
        #1;
        check_output("final_valid_count", 32'(valid_count), 32'(snap + 2));
        check_output("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
